// File: rtl/hex_date_decoder.sv
// Decodes a strobed stream of active-low 7-segment digit patterns back into a BCD date.
// Results (DATE_VALID or FRAME_ERR with ERR_CODE) are registered one cycle after the causing strobe.
module hex_date_decoder (
  input  logic        CLOCK_50,
  input  logic        RESET,
  input  logic [0:6]  SEG,
  input  logic        SEG_STB,
  input  logic        SEG_SOF,
  output logic [7:0]  DAY,
  output logic [7:0]  MONTH,
  output logic [15:0] YEAR,
  output logic        DATE_VALID,
  output logic        FRAME_ERR,
  output logic [2:0]  ERR_CODE
);

  typedef enum logic {IDLE, COLLECT} state_t;

  state_t     state;
  logic [2:0] idx;
  logic       bad;
  logic [3:0] dig [0:6];

  logic [3:0] cur;
  logic       cur_bad;

  // SEG[0] is segment a, so a literal written as abcdefg lines up with the vector directly.
  always_comb begin
    cur     = 4'd0;
    cur_bad = 1'b0;
    case (SEG)
      7'b0000001: cur = 4'd0;
      7'b1001111: cur = 4'd1;
      7'b0010010: cur = 4'd2;
      7'b0000110: cur = 4'd3;
      7'b1001100: cur = 4'd4;
      7'b0100100: cur = 4'd5;
      7'b0100000: cur = 4'd6;
      7'b0001111: cur = 4'd7;
      7'b0000000: cur = 4'd8;
      7'b0000100: cur = 4'd9;
      default:    cur_bad = 1'b1;
    endcase
  end

  // The year units digit is never stored: the frame is evaluated on the strobe that carries it.
  logic [7:0]  f_day;
  logic [7:0]  f_month;
  logic [15:0] f_year;
  logic        in_range;

  assign f_day    = {dig[0], dig[1]};
  assign f_month  = {dig[2], dig[3]};
  assign f_year   = {dig[4], dig[5], dig[6], cur};
  assign in_range = (f_day   >= 8'h01)   && (f_day   <= 8'h31) &&
                    (f_month >= 8'h01)   && (f_month <= 8'h12) &&
                    (f_year  >= 16'h1999) && (f_year  <= 16'h2030);

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      state      <= IDLE;
      idx        <= 3'd0;
      bad        <= 1'b0;
      for (int i = 0; i < 7; i++) dig[i] <= 4'd0;
      DAY        <= 8'h01;
      MONTH      <= 8'h01;
      YEAR       <= 16'h1999;
      DATE_VALID <= 1'b0;
      FRAME_ERR  <= 1'b0;
      ERR_CODE   <= 3'd0;
    end else begin
      DATE_VALID <= 1'b0;
      FRAME_ERR  <= 1'b0;
      if (SEG_STB) begin
        case (state)
          IDLE: begin
            if (SEG_SOF) begin
              dig[0] <= cur;
              bad    <= cur_bad;
              idx    <= 3'd1;
              state  <= COLLECT;
            end else begin
              FRAME_ERR <= 1'b1;
              ERR_CODE  <= 3'd3;
            end
          end
          COLLECT: begin
            if (SEG_SOF) begin
              FRAME_ERR <= 1'b1;
              ERR_CODE  <= 3'd2;
              dig[0]    <= cur;
              bad       <= cur_bad;
              idx       <= 3'd1;
            end else if (idx == 3'd7) begin
              if (bad || cur_bad) begin
                FRAME_ERR <= 1'b1;
                ERR_CODE  <= 3'd1;
              end else if (!in_range) begin
                FRAME_ERR <= 1'b1;
                ERR_CODE  <= 3'd4;
              end else begin
                DAY        <= f_day;
                MONTH      <= f_month;
                YEAR       <= f_year;
                DATE_VALID <= 1'b1;
              end
              state <= IDLE;
              idx   <= 3'd0;
              bad   <= 1'b0;
            end else begin
              dig[idx] <= cur;
              bad      <= bad | cur_bad;
              idx      <= idx + 3'd1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hex_date_decoder.sv
// Scoreboard bench for hex_date_decoder: a behavioural model queues expected pulses as digits are driven.
module tb_hex_date_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [0:6]  seg = 7'h7f;
  logic        seg_stb = 1'b0;
  logic        seg_sof = 1'b0;
  logic [7:0]  day, month;
  logic [15:0] year;
  logic        date_valid, frame_err;
  logic [2:0]  err_code;

  hex_date_decoder dut (
    .CLOCK_50   (clk),
    .RESET      (rst),
    .SEG        (seg),
    .SEG_STB    (seg_stb),
    .SEG_SOF    (seg_sof),
    .DAY        (day),
    .MONTH      (month),
    .YEAR       (year),
    .DATE_VALID (date_valid),
    .FRAME_ERR  (frame_err),
    .ERR_CODE   (err_code)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  typedef struct {
    int          cyc;
    bit          is_err;
    logic [2:0]  code;
    logic [7:0]  day;
    logic [7:0]  month;
    logic [15:0] year;
  } exp_t;

  exp_t q[$];

  // Reference model state
  bit          m_col;
  int          m_idx;
  bit          m_bad;
  int          m_val[8];
  logic [7:0]  m_day;
  logic [7:0]  m_month;
  logic [15:0] m_year;
  logic [2:0]  m_code;

  function automatic logic [6:0] enc(input int v);
    logic [6:0] tbl [10];
    tbl = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
            7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};
    return tbl[v];
  endfunction

  function automatic int dec(input logic [6:0] s);
    for (int v = 0; v < 10; v++) if (enc(v) == s) return v;
    return -1;
  endfunction

  task automatic model_reset();
    m_col = 0; m_idx = 0; m_bad = 0;
    m_day = 8'h01; m_month = 8'h01; m_year = 16'h1999; m_code = 3'd0;
  endtask

  task automatic push(input bit is_err, input logic [2:0] code);
    exp_t e;
    if (is_err) m_code = code;
    e.cyc = cyc + 1; e.is_err = is_err; e.code = m_code;
    e.day = m_day; e.month = m_month; e.year = m_year;
    q.push_back(e);
  endtask

  task automatic model_step(input logic [6:0] s, input logic sof);
    int v;
    int d, mo, y;
    v = dec(s);
    if (sof) begin
      if (m_col) push(1, 3'd2);
      m_col = 1; m_idx = 1; m_bad = (v < 0); m_val[0] = v;
    end else if (!m_col) begin
      push(1, 3'd3);
    end else begin
      m_val[m_idx] = v;
      if (v < 0) m_bad = 1;
      if (m_idx == 7) begin
        m_col = 0; m_idx = 0;
        if (m_bad) push(1, 3'd1);
        else begin
          d  = m_val[0] * 10 + m_val[1];
          mo = m_val[2] * 10 + m_val[3];
          y  = m_val[4] * 1000 + m_val[5] * 100 + m_val[6] * 10 + m_val[7];
          if (d < 1 || d > 31 || mo < 1 || mo > 12 || y < 1999 || y > 2030) push(1, 3'd4);
          else begin
            m_day   = 8'((m_val[0] << 4) | m_val[1]);
            m_month = 8'((m_val[2] << 4) | m_val[3]);
            m_year  = 16'((m_val[4] << 12) | (m_val[5] << 8) | (m_val[6] << 4) | m_val[7]);
            push(0, 3'd0);
          end
        end
        m_bad = 0;
      end else m_idx++;
    end
  endtask

  task automatic drive(input logic [6:0] s, input logic stb, input logic sof);
    @(posedge clk); #1;
    seg = s; seg_stb = stb; seg_sof = sof;
    if (stb) model_step(s, sof);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(7'($urandom), 1'b0, 1'($urandom));
  endtask

  // bcd = 32'hDDMMYYYY; bad_pos replaces that digit with a blank; gap inserts idle cycles.
  task automatic send_frame(input logic [31:0] bcd, input int bad_pos, input int n, input int gap);
    logic [6:0] s;
    for (int i = 0; i < n; i++) begin
      s = (i == bad_pos) ? 7'b1111111 : enc(int'(bcd[31-4*i -: 4]));
      drive(s, 1'b1, (i == 0));
      if (gap > 0) idle(gap);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_day"},   32'(day),        32'h01);
    check({tag, "_month"}, 32'(month),      32'h01);
    check({tag, "_year"},  32'(year),       32'h1999);
    check({tag, "_dv"},    32'(date_valid), 32'h0);
    check({tag, "_fe"},    32'(frame_err),  32'h0);
    check({tag, "_code"},  32'(err_code),   32'h0);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (date_valid || frame_err) begin
        check("both_pulses", 32'(date_valid & frame_err), 32'h0);
        if (q.size() == 0) check("spurious_pulse", 32'(date_valid | frame_err), 32'h0);
        else begin
          exp_t e;
          e = q.pop_front();
          check("pulse_cycle", 32'(cyc),        32'(e.cyc));
          check("frame_err",   32'(frame_err),  32'(e.is_err));
          check("date_valid",  32'(date_valid), 32'(!e.is_err));
          check("err_code",    32'(err_code),   32'(e.code));
          check("day",         32'(day),        32'(e.day));
          check("month",       32'(month),      32'(e.month));
          check("year",        32'(year),       32'(e.year));
        end
      end else if (q.size() > 0 && q[0].cyc <= cyc) begin
        check("missing_pulse", 32'h0, 32'h1);
        void'(q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1 check_reset_vals("reset");
    rst = 1'b0;

    send_frame(32'h25122019, -1, 8, 0);
    send_frame(32'h32012005, -1, 8, 0);
    send_frame(32'h01132020, -1, 8, 0);
    send_frame(32'h01012031, -1, 8, 0);
    send_frame(32'h01011999, -1, 8, 0);
    send_frame(32'h31122030, -1, 8, 0);
    send_frame(32'h00052010, -1, 8, 0);
    send_frame(32'h01001999, -1, 8, 0);
    send_frame(32'h01011998, -1, 8, 0);
    idle(2);
    send_frame(32'h14032015, 2, 8, 0);
    send_frame(32'h14032015, 7, 8, 0);
    idle(1);

    send_frame(32'h11112011, -1, 5, 0);
    send_frame(32'h15062024, -1, 8, 0);
    drive(enc(3), 1'b1, 1'b0);
    drive(enc(4), 1'b0, 1'b1);
    idle(2);
    send_frame(32'h09102022, -1, 8, 2);

    send_frame(32'h20202020, -1, 4, 0);
    @(posedge clk); #1;
    rst = 1'b1; seg_stb = 1'b0; seg_sof = 1'b0;
    model_reset();
    #2 check_reset_vals("midreset");
    @(posedge clk); #1 rst = 1'b0;
    send_frame(32'h07082021, -1, 8, 0);
    idle(4);
    check("queue_drained", 32'(q.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
